// File: rtl/pred_table_ctrl_if.sv
// Fetch-side lookup and branch-resolution update bundle
// for the direct-mapped branch prediction table.
interface pred_table_ctrl_if;
   logic [31:0] if_pc;
   logic        stall;
   logic [1:0]  hit_pred;
   logic [31:0] pred_target;
   logic [1:0]  hit_pred_d;
   logic [31:0] target_d;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        wrt;
   logic        wrp;
   logic        clear_all;
   logic        busy;
   logic [15:0] miss_cnt;

   modport master (
      output if_pc,
      output stall,
      output upd_pc,
      output upd_target,
      output upd_taken,
      output wrt,
      output wrp,
      output clear_all,
      input  hit_pred,
      input  pred_target,
      input  hit_pred_d,
      input  target_d,
      input  busy,
      input  miss_cnt
   );

   modport slave (
      input  if_pc,
      input  stall,
      input  upd_pc,
      input  upd_target,
      input  upd_taken,
      input  wrt,
      input  wrp,
      input  clear_all,
      output hit_pred,
      output pred_target,
      output hit_pred_d,
      output target_d,
      output busy,
      output miss_cnt
   );
endinterface

// File: rtl/pred_table_ctrl.sv
// Direct-mapped branch prediction table with a one-entry-per-cycle
// invalidation sweep, delayed lookup register and mispredict counter.
module pred_table_ctrl #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input logic           clk,
   input logic           rst_n,
   pred_table_ctrl_if.slave bus
);

   localparam int TAG_W = 30 - IDX_W;

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   logic [0:0]       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [1:0]       r_hit_pred_d;
   logic [31:0]      r_target_d;
   logic [15:0]      r_miss_cnt;

   logic             r_valid [ENTRIES];
   logic [TAG_W-1:0] r_tag   [ENTRIES];
   logic [31:0]      r_tgt   [ENTRIES];
   logic             r_pred  [ENTRIES];

   logic             w_run;
   logic [IDX_W-1:0] w_lidx;
   logic [TAG_W-1:0] w_ltag;
   logic             w_hit;
   logic [1:0]       w_hit_pred;
   logic [31:0]      w_pred_target;

   logic [IDX_W-1:0] w_uidx;
   logic [TAG_W-1:0] w_utag;
   logic             w_uhit;
   logic             w_do_wrt;
   logic             w_do_wrp;
   logic             w_unused;

   assign w_run  = (r_state == S_RUN);

   assign w_lidx = bus.if_pc[IDX_W+1:2];
   assign w_ltag = bus.if_pc[31:IDX_W+2];
   assign w_uidx = bus.upd_pc[IDX_W+1:2];
   assign w_utag = bus.upd_pc[31:IDX_W+2];

   // byte offset bits never take part in indexing or tagging
   assign w_unused = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

   assign w_hit = w_run
                & r_valid[w_lidx]
                & (r_tag[w_lidx] == w_ltag);

   assign w_hit_pred    = {w_hit, w_hit & r_pred[w_lidx]};
   assign w_pred_target = w_hit ? r_tgt[w_lidx] : 32'h0;

   assign w_uhit = r_valid[w_uidx]
                 & (r_tag[w_uidx] == w_utag);

   assign w_do_wrt = w_run & bus.wrt;
   assign w_do_wrp = w_run & bus.wrp & ~bus.wrt & w_uhit;

   // state and sweep index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_INIT;
         r_idx   <= '0;
      end else if (bus.clear_all) begin
         r_state <= S_INIT;
         r_idx   <= '0;
      end else if (r_state == S_INIT) begin
         if (r_idx == LAST_IDX) begin
            r_state <= S_RUN;
            r_idx   <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // table storage; only valid matters after a sweep
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) begin
         r_valid[r_idx] <= 1'b0;
      end else if (w_do_wrt) begin
         r_valid[w_uidx] <= 1'b1;
         r_tag[w_uidx]   <= w_utag;
         r_tgt[w_uidx]   <= bus.upd_target;
         r_pred[w_uidx]  <= bus.upd_taken;
      end else if (w_do_wrp) begin
         r_pred[w_uidx] <= bus.upd_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_pred_d <= 2'b00;
         r_target_d   <= 32'h0;
      end else if (bus.clear_all && w_run) begin
         r_hit_pred_d <= 2'b00;
         r_target_d   <= 32'h0;
      end else if (!bus.stall) begin
         r_hit_pred_d <= w_hit_pred;
         r_target_d   <= w_pred_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_miss_cnt <= 16'h0;
      end else if (w_do_wrp && (r_miss_cnt != 16'hFFFF)) begin
         r_miss_cnt <= r_miss_cnt + 16'h1;
      end
   end

   assign bus.hit_pred    = w_hit_pred;
   assign bus.pred_target = w_pred_target;
   assign bus.hit_pred_d  = r_hit_pred_d;
   assign bus.target_d    = r_target_d;
   assign bus.busy        = (r_state == S_INIT);
   assign bus.miss_cnt    = r_miss_cnt;

endmodule

// File: doc/pred_table_ctrl.md
PRED_TABLE_CTRL -- requirements
Module: pred_table_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped prediction entries (power of two).
REQ-002 SHALL have parameter IDX_W, default 4, log2(ENTRIES).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_pc  input  32  fetch PC for lookup.
REQ-006 SHALL have port stall  input  1  holds the delayed lookup register (hit_pred_d, target_d).
REQ-007 SHALL have port hit_pred  output  2  {H,P} for if_pc: H = valid tag hit, P = stored 1-bit prediction.
REQ-008 SHALL have port pred_target  output  32  stored target for if_pc, zero when H=0.
REQ-009 SHALL have port hit_pred_d  output  2  {Hd,Pd}, hit_pred delayed one unstalled cycle.
REQ-010 SHALL have port target_d  output  32  pred_target delayed one unstalled cycle.
REQ-011 SHALL have port upd_pc  input  32  PC of the resolving branch.
REQ-012 SHALL have port upd_target  input  32  resolved branch target.
REQ-013 SHALL have port upd_taken  input  1  resolved outcome (equal).
REQ-014 SHALL have port wrt  input  1  allocate/overwrite entry (tag, target, valid, prediction).
REQ-015 SHALL have port wrp  input  1  rewrite prediction bit only.
REQ-016 SHALL have port clear_all  input  1  single-cycle pulse requesting full table invalidation.
REQ-017 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-018 SHALL have port miss_cnt  output  16  count of accepted wrp-only updates (mispredictions on hit).

Function
REQ-019 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; entry = {valid, tag, target, pred}.
REQ-020 Lookup SHALL be combinational from if_pc: H = valid AND tag match; P = pred AND H; pred_target = target when H else 0.
REQ-021 FSM SHALL have states INIT and RUN; reset enters INIT with sweep index 0.
REQ-022 INIT SHALL clear valid of one entry per cycle, index 0..ENTRIES-1, then enter RUN on the cycle after index ENTRIES-1 is cleared (ENTRIES cycles in INIT).
REQ-023 busy SHALL be 1 exactly while in INIT; hit_pred SHALL be 2'b00 and pred_target 0 in INIT regardless of contents.
REQ-024 clear_all in RUN SHALL enter INIT at sweep index 0 next cycle; clear_all in INIT SHALL restart the sweep at index 0.
REQ-025 In INIT, wrt/wrp SHALL be dropped with no table or counter change.
REQ-026 In RUN, wrt=1 SHALL write valid=1, tag(upd_pc), target=upd_target, pred=upd_taken at index(upd_pc) on the next edge.
REQ-027 In RUN, wrp=1 with wrt=0 SHALL write pred=upd_taken only if the indexed entry is valid and tag matches upd_pc, else no change.
REQ-028 wrt and wrp both 1 SHALL behave as wrt alone; miss_cnt unchanged.
REQ-029 miss_cnt SHALL increment by 1 per accepted wrp-only write (REQ-027 condition true), saturating at 16'hFFFF.
REQ-030 Same-cycle lookup and write to the same index SHALL return pre-write contents; new contents visible the following cycle.
REQ-031 hit_pred_d/target_d SHALL load hit_pred/pred_target each edge when stall=0 and hold when stall=1.
REQ-032 clear_all in RUN SHALL zero hit_pred_d/target_d on the next edge, overriding stall.

Reset
REQ-033 rst_n low SHALL asynchronously force: state INIT, sweep index 0, busy=1, hit_pred_d=2'b00, target_d=0, miss_cnt=0.
REQ-034 Reset asserted mid-sweep or mid-RUN SHALL restart the full ENTRIES-cycle sweep after release; table contents other than valid need not reset.

Verification
REQ-035 Release rst_n -> busy=1 for exactly 16 cycles, hit_pred=00 throughout, busy=0 on cycle 17.
REQ-036 RUN, wrt=1, upd_pc=0x0000_0040, upd_target=0x0000_0100, upd_taken=1 -> next cycle if_pc=0x40 gives hit_pred=11, pred_target=0x100; if_pc=0x80 (same index, other tag) gives hit_pred=00.
REQ-037 After REQ-036, wrp=1, upd_pc=0x40, upd_taken=0 -> hit_pred=10, miss_cnt=1; wrp with upd_pc=0x80 -> no change, miss_cnt stays 1.
REQ-038 Lookup if_pc=0x40 with stall=1 for 3 cycles after a prediction change -> hit_pred_d holds its old value until stall=0, then updates on the next edge.
REQ-039 clear_all pulse in RUN with entry 0x40 valid -> busy=1 for 16 cycles, hit_pred_d=00 next cycle, wrt issued during sweep dropped, if_pc=0x40 gives 00 after sweep.
REQ-040 Preload miss_cnt to 0xFFFF via repeated wrp hits -> further accepted wrp keeps 0xFFFF; rst_n pulse mid-sweep -> sweep restarts at index 0, miss_cnt=0.
